// File: rtl/seg7_decoder_rx.sv
// rtl/seg7_decoder_rx.sv - seven-segment glyph receiver with stability filter and digit FIFO
module seg7_decoder_rx #(
    parameter int STABLE_CYCLES = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:6] seg_in,
    input  logic       seg_en,
    output logic [3:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       err,
    output logic       ovf,
    output logic [7:0] err_cnt,
    output logic [3:0] fifo_count
);
    localparam int          PW     = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  STABLE = 4'(STABLE_CYCLES);
    localparam logic [3:0]  DEPTH  = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

    // Returns {legal, digit}; pattern is abcdefg with a in the MSB position.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1111110: return 5'h10;
            7'b0110000: return 5'h11;
            7'b1101101: return 5'h12;
            7'b1111001: return 5'h13;
            7'b0110011: return 5'h14;
            7'b1011011: return 5'h15;
            7'b1011111: return 5'h16;
            7'b1110000: return 5'h17;
            7'b1111111: return 5'h18;
            7'b1111011: return 5'h19;
            7'b1110111: return 5'h1A;
            7'b0011111: return 5'h1B;
            7'b1001110: return 5'h1C;
            7'b0111101: return 5'h1D;
            7'b1001111: return 5'h1E;
            7'b1000111: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [0:6]      pat_q, pat_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            armed_q, armed_d;
    logic [3:0]      count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [3:0]      dout_q, dout_d;
    logic            err_q, err_d, ovf_q, ovf_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [3:0]      mem_q [FIFO_DEPTH];

    logic            active, load, accept, push, pop, wr;
    logic [4:0]      dec;

    always_comb begin
        active    = seg_en && (seg_in != 7'd0);
        dec       = decode(seg_in);
        load      = 1'b0;
        accept    = 1'b0;
        state_d   = state_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        // After reset the bus must be seen idle once before a pattern is tracked.
        armed_d   = armed_q || !active;
        case (state_q)
            IDLE: if (active && armed_q) load = 1'b1;
            TRACK: begin
                if (!active) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (seg_in != pat_q) begin
                    load = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    accept = (cnt_d == STABLE);
                end
            end
            HELD: begin
                if (!active) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (seg_in != pat_q) begin
                    load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = TRACK;
            pat_d   = seg_in;
            cnt_d   = 4'd1;
            accept  = (STABLE == 4'd1);
        end
        if (accept) state_d = HELD;

        pop      = (count_q != 4'd0) && dout_ready;
        push     = accept && dec[4];
        err_d    = accept && !dec[4];
        wr       = push && ((count_q < DEPTH) || pop);
        ovf_d    = push && !wr;
        count_d  = count_q + {3'd0, wr} - {3'd0, pop};
        wr_ptr_d = wr  ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_nxt   = rd_ptr_q + PW'(1);
        rd_ptr_d = pop ? rd_nxt : rd_ptr_q;

        // dout is a registered copy of the head; it holds once the FIFO drains.
        dout_d = dout_q;
        if (count_d != 4'd0) begin
            if (count_q == 4'd0)      dout_d = dec[3:0];
            else if (pop)             dout_d = (count_q == 4'd1) ? dec[3:0] : mem_q[rd_nxt];
        end

        err_cnt_d = (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            dout_q    <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            dout_q    <= dout_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr) mem_q[wr_ptr_q] <= dec[3:0];
    end

    assign dout       = dout_q;
    assign dout_valid = (count_q != 4'd0);
    assign err        = err_q;
    assign ovf        = ovf_q;
    assign err_cnt    = err_cnt_q;
    assign fifo_count = count_q;
endmodule

// File: tb/tb_seg7_decoder_rx.sv
// tb/tb_seg7_decoder_rx.sv - table-driven bench for seg7_decoder_rx
module tb_seg7_decoder_rx;
    logic       clk = 1'b0;
    logic       rst;
    logic [0:6] seg_in;
    logic       seg_en;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       err;
    logic       ovf;
    logic [7:0] err_cnt;
    logic [3:0] fifo_count;

    seg7_decoder_rx #(.STABLE_CYCLES(3), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .seg_en(seg_en),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .err(err), .ovf(ovf), .err_cnt(err_cnt), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] Z   = 7'b0000000;
    localparam logic [6:0] D0  = 7'b1111110;
    localparam logic [6:0] D1  = 7'b0110000;
    localparam logic [6:0] D2  = 7'b1101101;
    localparam logic [6:0] D3  = 7'b1111001;
    localparam logic [6:0] D4  = 7'b0110011;
    localparam logic [6:0] D5  = 7'b1011011;
    localparam logic [6:0] D7  = 7'b1110000;
    localparam logic [6:0] D8  = 7'b1111111;
    localparam logic [6:0] D9  = 7'b1111011;
    localparam logic [6:0] BAD = 7'b1010101;

    typedef struct {
        logic       en;
        logic [6:0] seg;
        logic       rdy;
        logic [3:0] d;
        logic       dv;
        logic       e;
        logic       o;
        logic [3:0] c;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic en, input logic [6:0] seg, input logic rdy,
                       input logic [3:0] d, input logic dv, input logic e, input logic o,
                       input logic [3:0] c, input logic [7:0] ec);
        vec_t v;
        v = '{en, seg, rdy, d, dv, e, o, c, ec};
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [6:0] seg, input logic rdy);
        @(negedge clk);
        rst = r; seg_en = en; seg_in = seg; dout_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] d, input logic dv, input logic e,
                           input logic o, input logic [3:0] c, input logic [7:0] ec);
        chk({tag, " dout"}, 8'(dout), 8'(d));
        chk({tag, " dout_valid"}, 8'(dout_valid), 8'(dv));
        chk({tag, " err"}, 8'(err), 8'(e));
        chk({tag, " ovf"}, 8'(ovf), 8'(o));
        chk({tag, " fifo_count"}, 8'(fifo_count), 8'(c));
        chk({tag, " err_cnt"}, err_cnt, ec);
    endtask

    initial begin
        int pulses;
        // single digit held five cycles: one push two edges after first sample
        add(1,D3,0, 0,0,0,0,0,0); add(1,D3,0, 0,0,0,0,0,0); add(1,D3,0, 3,1,0,0,1,0);
        add(1,D3,0, 3,1,0,0,1,0); add(1,D3,0, 3,1,0,0,1,0); add(1,Z,1,  3,0,0,0,0,0);
        // repeated digit with an intervening blank
        add(1,D0,0, 3,0,0,0,0,0); add(1,D0,0, 3,0,0,0,0,0); add(1,D0,0, 0,1,0,0,1,0);
        add(1,Z,0,  0,1,0,0,1,0);
        add(1,D0,0, 0,1,0,0,1,0); add(1,D0,0, 0,1,0,0,1,0); add(1,D0,0, 0,1,0,0,2,0);
        add(0,Z,1,  0,1,0,0,1,0); add(0,Z,1,  0,0,0,0,0,0);
        // pattern ignored while seg_en is low
        add(0,D5,0, 0,0,0,0,0,0); add(0,D5,0, 0,0,0,0,0,0); add(0,D5,0, 0,0,0,0,0,0);
        // illegal glyph
        add(1,BAD,0, 0,0,0,0,0,0); add(1,BAD,0, 0,0,0,0,0,0); add(1,BAD,0, 0,0,1,0,0,1);
        add(1,BAD,0, 0,0,0,0,0,1); add(1,Z,0,   0,0,0,0,0,1);
        // five back-to-back digits into a depth-4 FIFO, then drain
        add(1,D1,0, 0,0,0,0,0,1); add(1,D1,0, 0,0,0,0,0,1); add(1,D1,0, 1,1,0,0,1,1);
        add(1,D2,0, 1,1,0,0,1,1); add(1,D2,0, 1,1,0,0,1,1); add(1,D2,0, 1,1,0,0,2,1);
        add(1,D3,0, 1,1,0,0,2,1); add(1,D3,0, 1,1,0,0,2,1); add(1,D3,0, 1,1,0,0,3,1);
        add(1,D4,0, 1,1,0,0,3,1); add(1,D4,0, 1,1,0,0,3,1); add(1,D4,0, 1,1,0,0,4,1);
        add(1,D5,0, 1,1,0,0,4,1); add(1,D5,0, 1,1,0,0,4,1); add(1,D5,0, 1,1,0,1,4,1);
        add(1,Z,0,  1,1,0,0,4,1);
        add(0,Z,1,  2,1,0,0,3,1); add(0,Z,1, 3,1,0,0,2,1); add(0,Z,1, 4,1,0,0,1,1);
        add(0,Z,1,  4,0,0,0,0,1);
        // full FIFO with a simultaneous pop at acceptance
        add(1,D1,0, 4,0,0,0,0,1); add(1,D1,0, 4,0,0,0,0,1); add(1,D1,0, 1,1,0,0,1,1);
        add(1,D2,0, 1,1,0,0,1,1); add(1,D2,0, 1,1,0,0,1,1); add(1,D2,0, 1,1,0,0,2,1);
        add(1,D3,0, 1,1,0,0,2,1); add(1,D3,0, 1,1,0,0,2,1); add(1,D3,0, 1,1,0,0,3,1);
        add(1,D4,0, 1,1,0,0,3,1); add(1,D4,0, 1,1,0,0,3,1); add(1,D4,0, 1,1,0,0,4,1);
        add(1,D5,0, 1,1,0,0,4,1); add(1,D5,0, 1,1,0,0,4,1); add(1,D5,1, 2,1,0,0,4,1);
        add(1,Z,0,  2,1,0,0,4,1);
        add(0,Z,1,  3,1,0,0,3,1); add(0,Z,1, 4,1,0,0,2,1); add(0,Z,1, 5,1,0,0,1,1);
        add(0,Z,1,  5,0,0,0,0,1); add(0,Z,1, 5,0,0,0,0,1);

        rst = 1'b1; seg_en = 1'b0; seg_in = '0; dout_ready = 1'b0;
        step(1, 0, Z, 0);
        step(1, 0, Z, 0);
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        step(0, 0, Z, 0);

        foreach (tbl[i]) begin
            step(0, tbl[i].en, tbl[i].seg, tbl[i].rdy);
            chk_all($sformatf("row%0d", i), tbl[i].d, tbl[i].dv, tbl[i].e, tbl[i].o, tbl[i].c, tbl[i].ec);
        end

        // reset during a partially stable pattern with two entries queued
        for (int i = 0; i < 3; i++) step(0, 1, D7, 0);
        step(0, 1, Z, 0);
        for (int i = 0; i < 3; i++) step(0, 1, D9, 0);
        chk_all("queued", 7, 1, 0, 0, 2, 1);
        step(0, 1, D8, 0);
        step(0, 1, D8, 0);
        step(1, 1, D8, 0);
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
        step(0, 0, Z, 0);
        step(0, 1, D8, 0);
        step(0, 1, D8, 0);
        chk_all("rehold2", 0, 0, 0, 0, 0, 0);
        step(0, 1, D8, 0);
        chk_all("rehold3", 8, 1, 0, 0, 1, 0);
        step(0, 1, Z, 0);

        // err_cnt saturation
        pulses = 0;
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 3; k++) begin
                step(0, 1, BAD, 0);
                if (err === 1'b1) pulses++;
            end
            step(0, 1, Z, 0);
            if (err === 1'b1) pulses++;
        end
        chk("err_pulses", 8'(pulses - 45), 8'(255));
        chk("err_cnt_sat", err_cnt, 8'd255);
        chk("sat_fifo_count", 8'(fifo_count), 8'd1);
        chk("sat_dout", 8'(dout), 8'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg7_decoder_rx.md
SEG7_DECODER_RX -- requirements
Module: seg7_decoder_rx

Interface
REQ-001 Parameter STABLE_CYCLES, default 3: number of consecutive clock edges a segment pattern must be held unchanged before acceptance (legal range 1..15).
REQ-002 Parameter FIFO_DEPTH, default 4: number of decoded-digit entries buffered (power of two, 2..8).
REQ-003 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: seg_in  input  [0:6]  active-high segment bus; bit 0 = segment a through bit 6 = segment g.
REQ-007 Port: seg_en  input  1  segment bus valid; when low, seg_in is ignored.
REQ-008 Port: dout  output  [3:0]  decoded digit at the FIFO head.
REQ-009 Port: dout_valid  output  1  FIFO non-empty.
REQ-010 Port: dout_ready  input  1  consumer pops the head when dout_valid and dout_ready are both high at a clock edge.
REQ-011 Port: err  output  1  one-cycle pulse when a stable pattern is not a legal glyph.
REQ-012 Port: ovf  output  1  one-cycle pulse when a legal digit is dropped because the FIFO is full.
REQ-013 Port: err_cnt  output  [7:0]  saturating count of err pulses.
REQ-014 Port: fifo_count  output  [3:0]  current FIFO occupancy.

Function
REQ-015 Legal glyphs (seg_in[0:6] = abcdefg) SHALL decode as follows: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; 0000000 = blank.
REQ-016 FSM states SHALL be IDLE, TRACK, and HELD.
REQ-017 IDLE -> TRACK on seg_en=1 with a non-blank pattern; the pattern is latched and the stability counter is loaded with 1.
REQ-018 In TRACK, each edge with seg_en=1 and an unchanged pattern SHALL increment the counter; a changed non-blank pattern SHALL relatch it and reload the counter with 1; blank or seg_en=0 SHALL return to IDLE.
REQ-019 When the counter reaches STABLE_CYCLES, the FSM SHALL enter HELD at that edge and, in the same edge, either push the digit (legal glyph) or pulse err (illegal glyph).
REQ-020 With STABLE_CYCLES=3, a pattern first sampled at edge k and held produces the push at edge k+2; dout_valid is high after that edge if the FIFO was empty.
REQ-021 HELD SHALL emit nothing further for the same pattern; blank or seg_en=0 -> IDLE; a different non-blank pattern -> TRACK with the counter at 1.
REQ-022 Repeating the same digit SHALL require an intervening blank or seg_en=0 of at least one cycle.
REQ-023 The FIFO SHALL accept a push when fifo_count < FIFO_DEPTH, or when full with a pop in the same edge; otherwise the digit is dropped and ovf pulses.
REQ-024 A simultaneous push and pop SHALL leave fifo_count unchanged; output order is strictly first-in first-out.
REQ-025 Popping when empty SHALL have no effect; dout SHALL hold its last value while dout_valid=0.
REQ-026 err_cnt SHALL increment by 1 per err pulse and saturate at 255.

Reset
REQ-027 On rst=1 at an edge: FSM=IDLE, counter=0, FIFO emptied, fifo_count=0, dout=0, dout_valid=0, err=0, ovf=0, err_cnt=0.
REQ-028 rst SHALL take precedence over every other input in the same edge, including mid-TRACK and HELD; a partially stable pattern is discarded.
REQ-029 After release, one edge with an idle bus SHALL be needed before the FSM tracks a new pattern.

Verification
REQ-030 Hold 1111001 (3) with seg_en=1 for 5 cycles -> exactly one push; dout=3 and dout_valid=1 from edge k+2; err=0.
REQ-031 Sequence 1111110 x3, 0000000 x1, 1111110 x3, with dout_ready=0 -> fifo_count=2, both entries 0.
REQ-032 Hold 1010101 for 3 cycles -> single err pulse, err_cnt=1, fifo_count unchanged; 300 such events -> err_cnt=255.
REQ-033 Push 5 digits (1,2,3,4,5) with dout_ready=0 -> fifo_count=4, ovf pulses once on the 5th; then dout_ready=1 -> pops 1,2,3,4 in order.
REQ-034 FIFO full with dout_ready=1 during a new acceptance -> push and pop in the same edge, fifo_count stays 4, no ovf.
REQ-035 Assert rst while 8 is held for 2 of 3 cycles with 2 entries queued -> all outputs 0, no digit emitted after release until the pattern is re-held for 3 cycles.
